// File: rtl/flit_inject_arbiter_if.sv
// rtl/flit_inject_arbiter_if.sv - producer/network handshake bundle for the flit injection arbiter
interface flit_inject_arbiter_if #(
  parameter int NODE_COUNT      = 16,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int NUM_SRC         = 2
);
  localparam int FLIT_W = 1 + 2 * $clog2(NODE_COUNT) + 16 + 3 + PACKET_ID_WIDTH + 2;
  localparam int OWN_W  = $clog2(NUM_SRC);

  logic [NUM_SRC*FLIT_W-1:0] src_flits;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      net_ready;
  logic [FLIT_W-1:0]         flit_out;
  logic [OWN_W-1:0]          owner;
  logic                      busy;
  logic                      proto_err;

  modport master (
    output src_flits, net_ready,
    input  src_ready, flit_out, owner, busy, proto_err
  );

  modport slave (
    input  src_flits, net_ready,
    output src_ready, flit_out, owner, busy, proto_err
  );
endinterface

// File: rtl/flit_inject_arbiter.sv
// rtl/flit_inject_arbiter.sv - round-robin packet-atomic arbiter for a shared flit injection port
module flit_inject_arbiter #(
  parameter int NODE_COUNT      = 16,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int NUM_SRC         = 2,
  parameter int MAX_PKT_FLITS   = 8
) (
  input logic                 clk,
  input logic                 rst,
  flit_inject_arbiter_if.slave bus
);
  localparam int FLIT_W = 1 + 2 * $clog2(NODE_COUNT) + 16 + 3 + PACKET_ID_WIDTH + 2;
  localparam int OWN_W  = $clog2(NUM_SRC);
  localparam int CNT_W  = $clog2(MAX_PKT_FLITS + 1);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t             r_state;
  logic [OWN_W-1:0]   r_owner;
  logic [OWN_W-1:0]   r_rr;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_perr;
  logic [FLIT_W-1:0]  r_flit;

  logic [FLIT_W-1:0]  w_flit [NUM_SRC];
  logic [NUM_SRC-1:0] w_valid;
  logic [NUM_SRC-1:0] w_is_head;
  logic               w_out_free;
  logic               w_head_any;
  logic               w_orph_any;
  logic [OWN_W-1:0]   w_head_sel;
  logic [OWN_W-1:0]   w_orph_sel;
  logic [OWN_W-1:0]   w_pos;
  logic [OWN_W-1:0]   w_sel;
  logic               w_acc;
  logic               w_fwd;
  logic [NUM_SRC-1:0] w_ready;
  logic [1:0]         w_type;
  logic [CNT_W-1:0]   w_cnt_inc;
  int                 w_idx;

  function automatic logic [OWN_W-1:0] f_next(input logic [OWN_W-1:0] i);
    if (int'(i) == NUM_SRC - 1) return '0;
    return i + 1'b1;
  endfunction

  // Unpack per-source flits; type bit 0 set means head or single (a packet opener)
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      w_flit[i]    = bus.src_flits[i*FLIT_W +: FLIT_W];
      w_valid[i]   = w_flit[i][FLIT_W-1];
      w_is_head[i] = w_flit[i][0];
    end
  end

  assign w_out_free = !r_flit[FLIT_W-1] || bus.net_ready;

  // Scan from the round-robin pointer for the first opener and the first orphan body/tail
  always_comb begin
    w_head_any = 1'b0;
    w_orph_any = 1'b0;
    w_head_sel = '0;
    w_orph_sel = '0;
    w_idx      = 0;
    w_pos      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= NUM_SRC) w_idx = w_idx - NUM_SRC;
      w_pos = OWN_W'(w_idx);
      if (w_valid[w_pos] && w_is_head[w_pos] && !w_head_any) begin
        w_head_any = 1'b1;
        w_head_sel = w_pos;
      end
      if (w_valid[w_pos] && !w_is_head[w_pos] && !w_orph_any) begin
        w_orph_any = 1'b1;
        w_orph_sel = w_pos;
      end
    end
  end

  // Pick the source served this cycle: the owner while locked, else an opener, else an orphan to drop
  always_comb begin
    w_sel   = r_owner;
    w_acc   = 1'b0;
    w_fwd   = 1'b0;
    w_ready = '0;
    if (r_state == S_LOCKED) begin
      w_acc = w_out_free && w_valid[r_owner];
      w_fwd = 1'b1;
    end else if (w_head_any) begin
      w_sel = w_head_sel;
      w_acc = w_out_free;
      w_fwd = 1'b1;
    end else if (w_orph_any) begin
      w_sel = w_orph_sel;
      w_acc = w_out_free;
    end
    if (w_acc && !rst) w_ready[w_sel] = 1'b1;
  end

  assign w_type    = w_flit[w_sel][1:0];
  assign w_cnt_inc = r_cnt + 1'b1;

  // Output slot: refill whenever it frees, with the forwarded flit or an empty bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flit <= '0;
    end else if (w_out_free) begin
      r_flit <= (w_acc && w_fwd) ? w_flit[w_sel] : '0;
    end
  end

  // Packet lock FSM: ownership, round-robin pointer, length watchdog and sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_rr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_perr  <= 1'b0;
    end else if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          if (!w_fwd) begin
            r_perr <= 1'b1;
          end else if (w_type == 2'b01) begin
            r_state <= S_LOCKED;
            r_owner <= w_sel;
            r_cnt   <= CNT_W'(1);
            r_busy  <= 1'b1;
          end else begin
            r_rr <= f_next(w_sel);
          end
        end
        default: begin
          if (w_type == 2'b10) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_rr    <= f_next(r_owner);
          end else if (w_type == 2'b01) begin
            r_perr <= 1'b1;
            r_cnt  <= CNT_W'(1);
          end else begin
            if (w_type == 2'b11) r_perr <= 1'b1;
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc >= CNT_W'(MAX_PKT_FLITS)) begin
              r_perr  <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_rr    <= f_next(r_owner);
            end
          end
        end
      endcase
    end
  end

  assign bus.src_ready = w_ready;
  assign bus.flit_out  = r_flit;
  assign bus.owner     = r_owner;
  assign bus.busy      = r_busy;
  assign bus.proto_err = r_perr;
endmodule

// File: doc/flit_inject_arbiter.md
# flit_inject_arbiter

Shares one router local injection port among `NUM_SRC` flit producers, for example a tile's splitter plus a DMA or debug injector. Packets are never interleaved. A source that wins arbitration with a head flit owns the port until its tail flit is accepted. Winners are chosen round-robin. The block sits between the producers and the network's `networkReady`/flit input, behind a one-entry registered output stage.

## Interface
Parameters:
- `NODE_COUNT`, 16: network node count; sets the address field widths.
- `PACKET_ID_WIDTH`, 5: packet ID field width.
- `NUM_SRC`, 2: number of requesters, ≥2.
- `MAX_PKT_FLITS`, 8: maximum flits per packet before forced release.
- `FLIT_W`, derived, not overridable: 1 + 2·$clog2(NODE_COUNT) + 16 + 3 + PACKET_ID_WIDTH + 2. With defaults this is 35.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `src_flits` in NUM_SRC·FLIT_W: packed flits. Source i occupies bits [i·FLIT_W +: FLIT_W].
- `src_ready` out NUM_SRC: source i's flit is consumed this cycle.
- `net_ready` in 1: the network accepts `flit_out` this cycle.
- `flit_out` out FLIT_W: the registered output flit.
- `owner` out $clog2(NUM_SRC): index of the locked source. Valid only while `busy` is high.
- `busy` out 1: a multi-flit packet is in progress.
- `proto_err` out 1: sticky protocol-error flag. Cleared only by `rst`.

## Operation
Flit format:
- Bit FLIT_W-1 is `valid`.
- Bits [1:0] are the flit type: 01 head, 00 body, 10 tail, 11 single (head and tail).
- All other fields pass through unmodified.

Output stage:
- `out_free = !flit_out[FLIT_W-1] || net_ready`.
- When `out_free` is high, the granted flit, if any, is loaded. Otherwise the register holds.
- If `out_free` is high and no source is granted, the register loads all-zero.

FSM:
- **IDLE**
  - Candidates are sources with valid=1 and type head or single.
  - The winner is the first candidate found scanning `rr_ptr`, `rr_ptr`+1, … modulo NUM_SRC.
  - `src_ready[winner] = out_free`. All other `src_ready` bits are 0.
  - On acceptance of a head flit: go to LOCKED, set `owner = winner`, set `cnt = 1`.
  - On acceptance of a single flit: stay in IDLE, set `rr_ptr = winner+1` modulo NUM_SRC.
- **LOCKED**
  - Only `owner` is eligible: `src_ready[owner] = out_free && valid[owner]`.
  - Valid flits from other sources wait with ready=0.
  - Each accepted owner flit increments `cnt`.
  - Accepted tail: go to IDLE, set `rr_ptr = owner+1`.
  - Accepted head or single from the owner is a protocol error:
    - set `proto_err`;
    - forward the flit;
    - a single keeps LOCKED; a head restarts `cnt` at 1.
- Unlocked source with a valid body or tail while in IDLE:
  - it is acknowledged (`src_ready` = 1 when `out_free`);
  - the flit is dropped and not forwarded;
  - `proto_err` is set;
  - it takes priority over head arbitration that cycle only if no head candidate exists.
- Watchdog: when `cnt` reaches MAX_PKT_FLITS and the accepted flit is not a tail:
  - set `proto_err`;
  - force IDLE and set `rr_ptr = owner+1`.
- `cnt` width is $clog2(MAX_PKT_FLITS+1). It never wraps because the watchdog fires first.

## Timing
- Reset values: `flit_out` = 0, `busy` = 0, `owner` = 0, `proto_err` = 0, `rr_ptr` = 0, state IDLE.
- `src_ready` is forced to 0 while `rst` is high.
- `src_ready` is combinational from `src_flits`, state and `net_ready`. There is no combinational path from `src_flits` to `flit_out`.
- Latency: a flit accepted at edge N appears on `flit_out` after edge N. It leaves at the first edge where `net_ready`=1.
- Throughput: 1 flit/cycle while `net_ready` stays high.
- Back-to-back packets: when a tail is accepted at edge N, a new head from any source can be accepted at edge N+1.
- Stall: with `net_ready`=0 and the output full, every `src_ready` is 0 and `flit_out` is stable.
- `busy` is high from the edge that accepts a head until the edge that accepts the tail (or the watchdog release).
- Reset during a packet aborts it immediately. A partial packet may already have been emitted. Downstream recovery is out of scope.

## Test plan
- **Single-flit round-robin.** Src0 and src1 both hold single flits continuously, `net_ready`=1.
  - Grants alternate 0,1,0,1, starting with 0 after reset.
  - `flit_out` changes every cycle.
  - `busy` stays 0.
- **Packet atomicity.** Src0 sends head,body,body,tail. Src1 presents a head from cycle 2.
  - `flit_out` shows src0's 4 flits consecutively, then src1's head.
  - `src_ready[1]`=0 until src0's tail is accepted.
- **Backpressure.** `net_ready` is 0 for 3 cycles mid-packet.
  - `flit_out` holds the same body flit.
  - `src_ready`=0 throughout.
  - Resumes without loss or duplication.
- **Orphan body.** Src1 drives a body flit in IDLE with no head pending.
  - The flit is acknowledged in 1 cycle.
  - `flit_out` valid=0.
  - `proto_err`=1 and remains set.
- **Watchdog.** With MAX_PKT_FLITS=8, src0 sends a head then 9 bodies.
  - The 8th accepted flit sets `proto_err` and forces IDLE.
  - Src1's pending head wins next.
- **Async reset mid-packet.** `rst` pulses during the body of src0's packet.
  - Outputs take their reset values immediately, without waiting for `clk`.
  - `rr_ptr` = 0.
